// File: rtl/fifo_pkg.sv
// Pointer/level types and frame sequencer states for the input-buffer FIFOs.
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int N_W_DEF    = 4;

  // Pointers carry one extra wrap bit above the RAM address.
  typedef logic [ADDR_W_DEF:0] ptr_t;
  typedef logic [ADDR_W_DEF:0] level_t;

  typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} frame_state_e;

endpackage

// File: rtl/global_pkg.sv
// Shared constants and small types used across the matrix datapath.
package global_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/fifo_frame_ptrs_frame_seq.sv
// Frame sequencer: follows one n*n matrix load from first push to last pop.
module frame_seq
  import global_pkg::*;
  import fifo_pkg::*;
#(
  parameter int N_W = N_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           push_ok,
  input  logic           pop_ok,
  input  logic [N_W-1:0] n,
  output logic           frame_ready,
  output logic           frame_done
);

  localparam int CW = 2 * N_W;

  frame_state_e  state_q;
  logic [CW-1:0] target_q;
  logic [CW-1:0] push_cnt_q;
  logic [CW-1:0] pop_cnt_q;
  logic [CW-1:0] n_sq;

  assign n_sq = {{N_W{1'b0}}, n} * {{N_W{1'b0}}, n};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
      frame_done <= FALSE;
    end else if (clear) begin
      state_q    <= IDLE;
      target_q   <= '0;
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
      frame_done <= FALSE;
    end else begin
      frame_done <= FALSE;
      case (state_q)
        IDLE: begin
          if (push_ok) begin
            target_q   <= n_sq;
            push_cnt_q <= CW'(1);
            // n = 0 describes an empty matrix, so no frame is started.
            if (n != '0)
              state_q <= (n_sq == CW'(1)) ? READY : FILL;
          end
        end
        FILL: begin
          if (push_ok) begin
            push_cnt_q <= push_cnt_q + CW'(1);
            if (push_cnt_q + CW'(1) == target_q)
              state_q <= READY;
          end
        end
        READY: begin
          if (pop_ok) begin
            if (target_q == CW'(1)) begin
              state_q    <= IDLE;
              frame_done <= TRUE;
            end else begin
              pop_cnt_q <= CW'(1);
              state_q   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop_ok) begin
            pop_cnt_q <= pop_cnt_q + CW'(1);
            if (pop_cnt_q + CW'(1) == target_q) begin
              state_q    <= IDLE;
              frame_done <= TRUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_ready = (state_q == READY);

endmodule

// File: rtl/fifo_frame_ptrs.sv
// FIFO pointer/flag controller with frame sequencer for the matrix input buffers.
// Define FIFO_PTR_ERR_EN to build the sticky overflow/underflow flags.
module fifo_frame_ptrs
  import global_pkg::*;
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int N_W       = N_W_DEF,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [N_W-1:0]    n,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              push_ok,
  output logic              pop_ok,
  output logic              frame_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W + 1)'(AE_MARGIN);

  logic [ADDR_W:0] wr_q;
  logic [ADDR_W:0] rd_q;

  // Flags decode straight from the registered pointers, so they settle one edge after a request.
  assign empty        = (wr_q == rd_q);
  assign full         = (wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0]) && (wr_q[ADDR_W] != rd_q[ADDR_W]);
  assign level        = wr_q - rd_q;
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  assign push_ok = push & ~full & ~clear;
  assign pop_ok  = pop & ~empty & ~clear;

  assign wr_ptr = wr_q[ADDR_W-1:0];
  assign rd_ptr = rd_q[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

`ifdef FIFO_PTR_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= FALSE;
      underflow_q <= FALSE;
    end else if (clear) begin
      overflow_q  <= FALSE;
      underflow_q <= FALSE;
    end else begin
      if (push && full)  overflow_q  <= TRUE;
      if (pop && empty)  underflow_q <= TRUE;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = FALSE;
  assign underflow = FALSE;
`endif

  frame_seq #(.N_W(N_W)) u_frame_seq (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .push_ok     (push_ok),
    .pop_ok      (pop_ok),
    .n           (n),
    .frame_ready (frame_ready),
    .frame_done  (frame_done)
  );

endmodule

// File: tb/tb_fifo_frame_ptrs.sv
// Self-checking bench for fifo_frame_ptrs: reference model plus address scoreboard.
module tb_fifo_frame_ptrs;

  logic       clk = 1'b0;
  logic       rst, clear, push, pop;
  logic [3:0] n;
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] level;
  logic       empty, full, almost_empty, almost_full;
  logic       push_ok, pop_ok, frame_ready, frame_done, overflow, underflow;

  int errors = 0;
  int checks = 0;

  // Write addresses queued on accepted pushes, expected on rd_ptr at the matching pop.
  logic [3:0] sb[$];

  int m_wr, m_rd, m_state, m_target, m_pc, m_qc;
  bit m_done, m_ovf, m_udf;

  fifo_frame_ptrs dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .push         (push),
    .pop          (pop),
    .n            (n),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .push_ok      (push_ok),
    .pop_ok       (pop_ok),
    .frame_ready  (frame_ready),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int mLevel();
    return (m_wr - m_rd) & 31;
  endfunction

  task automatic resetModel();
    m_wr = 0; m_rd = 0; m_state = 0; m_target = 0; m_pc = 0; m_qc = 0;
    m_done = 0; m_ovf = 0; m_udf = 0;
    sb.delete();
  endtask

  task automatic checkState();
    int lvl;
    lvl = mLevel();
    checkOutput("level", 32'(level), 32'(lvl));
    checkOutput("wr_ptr", 32'(wr_ptr), 32'(m_wr & 15));
    checkOutput("rd_ptr", 32'(rd_ptr), 32'(m_rd & 15));
    checkOutput("empty", 32'(empty), 32'(lvl == 0));
    checkOutput("full", 32'(full), 32'(lvl == 16));
    checkOutput("almost_empty", 32'(almost_empty), 32'(lvl <= 2));
    checkOutput("almost_full", 32'(almost_full), 32'(lvl >= 14));
    checkOutput("frame_ready", 32'(frame_ready), 32'(m_state == 2));
    checkOutput("frame_done", 32'(frame_done), 32'(m_done));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("underflow", 32'(underflow), 32'(m_udf));
  endtask

  // One clock of stimulus: check the same-cycle handshake, clock it, then check registered state.
  task automatic applyStimulus(input bit p, input bit q, input bit c);
    bit         pok, qok;
    int         lvl;
    logic [4:0] exp_addr;
    push = p; pop = q; clear = c;
    #1;
    lvl = mLevel();
    pok = p && !c && (lvl != 16);
    qok = q && !c && (lvl != 0);
    checkOutput("push_ok", 32'(push_ok), 32'(pok));
    checkOutput("pop_ok", 32'(pop_ok), 32'(qok));
    if (qok) begin
      exp_addr = 5'h10;
      if (sb.size() > 0) exp_addr = {1'b0, sb.pop_front()};
      checkOutput("rd_addr", 32'(rd_ptr), 32'(exp_addr));
    end
    if (pok) sb.push_back(4'(m_wr));
    @(posedge clk);
    if (c) begin
      resetModel();
    end else begin
`ifdef FIFO_PTR_ERR_EN
      if (p && lvl == 16) m_ovf = 1;
      if (q && lvl == 0)  m_udf = 1;
`endif
      m_done = 0;
      case (m_state)
        0: if (pok) begin
             m_target = int'(n) * int'(n);
             m_pc = 1;
             if (n != 0) m_state = (m_target == 1) ? 2 : 1;
           end
        1: if (pok) begin
             m_pc++;
             if (m_pc == m_target) m_state = 2;
           end
        2: if (qok) begin
             if (m_target == 1) begin m_state = 0; m_done = 1; end
             else begin m_qc = 1; m_state = 3; end
           end
        default: if (qok) begin
             m_qc++;
             if (m_qc == m_target) begin m_state = 0; m_done = 1; end
           end
      endcase
      if (pok) m_wr = (m_wr + 1) & 31;
      if (qok) m_rd = (m_rd + 1) & 31;
    end
    #1;
    checkState();
  endtask

  task automatic pulseReset();
    push = 0; pop = 0; clear = 0;
    rst = 0;
    #1;
    resetModel();
    checkState();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    rst = 1; clear = 0; push = 0; pop = 0; n = 4'd0;
    #2;
    pulseReset();

    // Pop from empty right after reset.
    applyStimulus(0, 1, 0);

    // n=3 frame: 9 pushes fill it, 9 pops drain it.
    n = 4'd3;
    repeat (9) applyStimulus(1, 0, 0);
    repeat (9) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    // Fill to full without a frame, then overflow attempt.
    applyStimulus(0, 0, 1);
    n = 4'd0;
    repeat (17) applyStimulus(1, 0, 0);
    repeat (11) applyStimulus(0, 1, 0);
    repeat (40) applyStimulus(1, 1, 0);

    // Clear in FILL with a simultaneous push.
    applyStimulus(0, 0, 1);
    n = 4'd3;
    repeat (4) applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);

    // Reset mid-DRAIN, then a complete n=2 frame.
    n = 4'd2;
    repeat (4) applyStimulus(1, 0, 0);
    repeat (2) applyStimulus(0, 1, 0);
    pulseReset();
    repeat (4) applyStimulus(1, 0, 0);
    repeat (4) applyStimulus(0, 1, 0);

    // Single-word frame: n=1 goes straight to READY and back.
    n = 4'd1;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      if (m_state == 0 && $urandom_range(0, 3) == 0) n = 4'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
